dram_rdq: RTL and testbench

DRAM_RDQ -- requirements
Module: dram_rdq

---
 rtl/dram_rdq_pkg.sv | 18 +
 rtl/dram_rdq_mem.sv | 28 ++
 rtl/dram_rdq.sv | 143 ++++++++++++++
 tb/tb_dram_rdq.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/dram_rdq_pkg.sv
// Shared types and constants for the DRAM read-return queue.
// Entry layout: 256-bit data, 32-bit ECC, last-beat flag.
package dram_rdq_pkg;

    localparam int DATA_W    = 256;
    localparam int ECC_W     = 32;
    localparam int DEF_DEPTH = 4;
    localparam int DEF_BEATS = 2;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ECC_W-1:0]  ecc;
        logic              last;
    } rdq_entry_t;

    localparam int ENTRY_W = $bits(rdq_entry_t);

endpackage

// File: rtl/dram_rdq_mem.sv
// DEPTH x 289 register file for the read-return queue.
// One write port, one combinational read port, no reset on the stored data.
module dram_rdq_mem
    import dram_rdq_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  rdq_entry_t      wr_entry,
    input  logic [AW-1:0]   rd_addr,
    output rdq_entry_t      rd_entry
);

    rdq_entry_t mem_r [DEPTH];

    // Write port: capture one entry per enabled clock.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_entry;
        end
    end

    assign rd_entry = mem_r[rd_addr];

endmodule

// File: rtl/dram_rdq.sv
// DRAM read-return queue: buffers read beats from the pad repeater and tags burst ends.
// Optional same-cycle bypass into an empty queue is enabled with `define DRAM_RDQ_BYPASS_EN.
module dram_rdq
    import dram_rdq_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int BEATS = DEF_BEATS
) (
    input  logic                     rclk,
    input  logic                     arst_l,
    input  logic                     io_dram_data_valid_buf,
    input  logic [DATA_W-1:0]        io_dram_data_in_buf,
    input  logic [ECC_W-1:0]         io_dram_ecc_in_buf,
    input  logic                     dram_io_channel_disabled_buf,
    input  logic                     rdq_rdy,
    input  logic                     rdq_ovfl_clr,
    output logic                     rdq_vld,
    output logic [DATA_W-1:0]        rdq_data,
    output logic [ECC_W-1:0]         rdq_ecc,
    output logic                     rdq_last,
    output logic [$clog2(DEPTH):0]   rdq_cnt,
    output logic                     rdq_ovfl
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(BEATS);
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] cnt_r;
    logic [BW-1:0] beat_r;
    logic          ovfl_r;

    logic          push_s;
    logic          pop_s;
    logic          empty_s;
    logic          full_s;
    logic          byp_s;
    logic          store_s;
    logic          drop_s;
    rdq_entry_t    in_entry_s;
    rdq_entry_t    head_s;

    assign push_s  = io_dram_data_valid_buf & ~dram_io_channel_disabled_buf;
    assign empty_s = (cnt_r == '0);
    assign full_s  = (cnt_r == FULL_CNT);
    assign pop_s   = ~empty_s & rdq_rdy;

`ifdef DRAM_RDQ_BYPASS_EN
    assign byp_s   = push_s & empty_s & rdq_rdy;
`else
    assign byp_s   = 1'b0;
`endif

    // A pop frees the slot being written, so a full queue still accepts a beat alongside it.
    assign store_s = push_s & ~byp_s & (~full_s | pop_s);
    assign drop_s  = push_s & full_s & ~pop_s;

    assign in_entry_s.data = io_dram_data_in_buf;
    assign in_entry_s.ecc  = io_dram_ecc_in_buf;
    assign in_entry_s.last = (beat_r == LAST_BEAT);

    dram_rdq_mem #(.DEPTH(DEPTH)) u_mem (
        .clk      (rclk),
        .wr_en    (store_s),
        .wr_addr  (wr_ptr_r),
        .wr_entry (in_entry_s),
        .rd_addr  (rd_ptr_r),
        .rd_entry (head_s)
    );

    // Pointers, occupancy and burst beat counter; channel disable flushes them.
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            cnt_r    <= '0;
            beat_r   <= '0;
        end else if (dram_io_channel_disabled_buf) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            cnt_r    <= '0;
            beat_r   <= '0;
        end else begin
            if (store_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({store_s, pop_s})
                2'b10:   cnt_r <= cnt_r + CW'(1);
                2'b01:   cnt_r <= cnt_r - CW'(1);
                default: cnt_r <= cnt_r;
            endcase
            // Dropped and bypassed beats still belong to the burst.
            if (push_s) begin
                beat_r <= (beat_r == LAST_BEAT) ? '0 : beat_r + BW'(1);
            end
        end
    end

    // Sticky overflow flag; a new drop outranks a clear in the same cycle.
    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            ovfl_r <= 1'b0;
        end else if (drop_s) begin
            ovfl_r <= 1'b1;
        end else if (rdq_ovfl_clr) begin
            ovfl_r <= 1'b0;
        end else begin
            ovfl_r <= ovfl_r;
        end
    end

    // Head presentation; outputs read zero whenever nothing is valid.
    always_comb begin
        rdq_vld  = 1'b0;
        rdq_data = '0;
        rdq_ecc  = '0;
        rdq_last = 1'b0;
        if (byp_s) begin
            rdq_vld  = 1'b1;
            rdq_data = in_entry_s.data;
            rdq_ecc  = in_entry_s.ecc;
            rdq_last = in_entry_s.last;
        end else if (!empty_s) begin
            rdq_vld  = 1'b1;
            rdq_data = head_s.data;
            rdq_ecc  = head_s.ecc;
            rdq_last = head_s.last;
        end else begin
            rdq_vld  = 1'b0;
        end
    end

    assign rdq_cnt  = cnt_r;
    assign rdq_ovfl = ovfl_r;

endmodule

// File: tb/tb_dram_rdq.sv
// Testbench for dram_rdq: table-driven vectors plus a scoreboard of expected head entries.
// Follows DRAM_RDQ_BYPASS_EN when it is defined for the build.
module tb_dram_rdq;
    import dram_rdq_pkg::*;

    localparam int DEPTH = 4;
    localparam int BEATS = 2;

    logic          rclk = 1'b0;
    logic          arst_l;
    logic          vin;
    logic [255:0]  din;
    logic [31:0]   ein;
    logic          dis;
    logic          rdy;
    logic          clr;
    logic          rdq_vld;
    logic [255:0]  rdq_data;
    logic [31:0]   rdq_ecc;
    logic          rdq_last;
    logic [2:0]    rdq_cnt;
    logic          rdq_ovfl;

    dram_rdq #(.DEPTH(DEPTH), .BEATS(BEATS)) dut (
        .rclk                         (rclk),
        .arst_l                       (arst_l),
        .io_dram_data_valid_buf       (vin),
        .io_dram_data_in_buf          (din),
        .io_dram_ecc_in_buf           (ein),
        .dram_io_channel_disabled_buf (dis),
        .rdq_rdy                      (rdy),
        .rdq_ovfl_clr                 (clr),
        .rdq_vld                      (rdq_vld),
        .rdq_data                     (rdq_data),
        .rdq_ecc                      (rdq_ecc),
        .rdq_last                     (rdq_last),
        .rdq_cnt                      (rdq_cnt),
        .rdq_ovfl                     (rdq_ovfl)
    );

    always #5 rclk = ~rclk;

    typedef struct {
        logic [255:0] data;
        logic [31:0]  ecc;
        logic         last;
    } exp_t;

    typedef struct {
        bit         v;
        logic [7:0] tag;
        bit         rdy;
        bit         dis;
        bit         clr;
        int         cnt;
        bit         ovfl;
    } vec_t;

    exp_t sb[$];
    int   bc = 0;
    bit   m_ovfl = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outputs();
        check("vld", 256'(rdq_vld), 256'(sb.size() != 0));
        check("cnt", 256'(rdq_cnt), 256'(sb.size()));
        check("ovfl", 256'(rdq_ovfl), 256'(m_ovfl));
        if (sb.size() != 0) begin
            check("data", rdq_data, sb[0].data);
            check("ecc", 256'(rdq_ecc), 256'(sb[0].ecc));
            check("last", 256'(rdq_last), 256'(sb[0].last));
        end else begin
            check("data_idle", rdq_data, 256'(0));
            check("ecc_idle", 256'(rdq_ecc), 256'(0));
            check("last_idle", 256'(rdq_last), 256'(0));
        end
    endtask

    // One clock: drive inputs, update the reference queue at the edge, compare after it.
    task automatic apply(input bit v, input logic [7:0] tag, input bit r, input bit d, input bit c);
        bit   byp;
        bit   pop;
        bit   full;
        bit   set;
        exp_t e;
        vin = v;
        din = {32{tag}};
        ein = {4{~tag}};
        rdy = r;
        dis = d;
        clr = c;
        #3;
        byp = 1'b0;
        if (v && !d && r && sb.size() == 0) begin
`ifdef DRAM_RDQ_BYPASS_EN
            byp = 1'b1;
            check("byp_vld", 256'(rdq_vld), 256'(1));
            check("byp_data", rdq_data, din);
            check("byp_last", 256'(rdq_last), 256'(bc == BEATS - 1));
`else
            check("nobyp_vld", 256'(rdq_vld), 256'(0));
`endif
        end
        @(posedge rclk);
        #1;
        set = 1'b0;
        if (d) begin
            sb.delete();
            bc = 0;
        end else begin
            pop  = (sb.size() != 0) && r;
            full = (sb.size() == DEPTH);
            e.data = din;
            e.ecc  = ein;
            e.last = (bc == BEATS - 1);
            if (pop) void'(sb.pop_front());
            if (v) begin
                if (!byp) begin
                    if (!full || pop) sb.push_back(e);
                    else set = 1'b1;
                end
                bc = (bc + 1) % BEATS;
            end
        end
        if (set) m_ovfl = 1'b1;
        else if (c) m_ovfl = 1'b0;
        check_outputs();
    endtask

    vec_t tbl[26];

    initial begin
        tbl = '{
            '{1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 1, 1'b0},
            '{1'b1, 8'hBB, 1'b0, 1'b0, 1'b0, 2, 1'b0},
            '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1, 1'b0},
            '{1'b1, 8'hC1, 1'b0, 1'b0, 1'b0, 2, 1'b0},
            '{1'b1, 8'hC2, 1'b0, 1'b0, 1'b0, 3, 1'b0},
            '{1'b1, 8'hC3, 1'b0, 1'b0, 1'b0, 4, 1'b0},
            '{1'b1, 8'hC4, 1'b0, 1'b0, 1'b0, 4, 1'b1},
            '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4, 1'b0},
            '{1'b1, 8'hD1, 1'b1, 1'b0, 1'b0, 4, 1'b0},
            '{1'b1, 8'hD2, 1'b0, 1'b0, 1'b1, 4, 1'b1},
            '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 4, 1'b0},
            '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3, 1'b0},
            '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 2, 1'b0},
            '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1, 1'b0},
            '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 1'b0},
            '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 1'b0},
            '{1'b1, 8'hE1, 1'b0, 1'b0, 1'b0, 1, 1'b0},
            '{1'b1, 8'hE2, 1'b0, 1'b0, 1'b0, 2, 1'b0},
            '{1'b1, 8'hE3, 1'b0, 1'b0, 1'b0, 3, 1'b0},
            '{1'b1, 8'hE4, 1'b0, 1'b0, 1'b0, 4, 1'b0},
            '{1'b1, 8'hE5, 1'b0, 1'b0, 1'b0, 4, 1'b1},
            '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 3, 1'b1},
            '{1'b1, 8'hE6, 1'b0, 1'b1, 1'b0, 0, 1'b1},
            '{1'b1, 8'hF1, 1'b0, 1'b0, 1'b0, 1, 1'b1},
            '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1, 1'b0},
            '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 1'b0}
        };

        arst_l = 1'b1;
        vin = 1'b0;
        din = '0;
        ein = '0;
        dis = 1'b0;
        rdy = 1'b0;
        clr = 1'b0;
        #2 arst_l = 1'b0;
        #1;
        check("rst_vld", 256'(rdq_vld), 256'(0));
        check("rst_cnt", 256'(rdq_cnt), 256'(0));
        check("rst_ovfl", 256'(rdq_ovfl), 256'(0));
        check("rst_last", 256'(rdq_last), 256'(0));
        check("rst_data", rdq_data, 256'(0));
        @(posedge rclk);
        #1 arst_l = 1'b1;

        for (int i = 0; i < 26; i++) begin
            apply(tbl[i].v, tbl[i].tag, tbl[i].rdy, tbl[i].dis, tbl[i].clr);
            check($sformatf("tbl%0d_cnt", i), 256'(rdq_cnt), 256'(tbl[i].cnt));
            check($sformatf("tbl%0d_ovfl", i), 256'(rdq_ovfl), 256'(tbl[i].ovfl));
        end

        // Asynchronous reset in the middle of a burst, away from any clock edge.
        apply(1'b1, 8'h51, 1'b0, 1'b0, 1'b0);
        #2 arst_l = 1'b0;
        #1;
        check("arst_vld", 256'(rdq_vld), 256'(0));
        check("arst_cnt", 256'(rdq_cnt), 256'(0));
        check("arst_last", 256'(rdq_last), 256'(0));
        check("arst_data", rdq_data, 256'(0));
        sb.delete();
        bc = 0;
        m_ovfl = 1'b0;
        #2 arst_l = 1'b1;
        apply(1'b1, 8'h61, 1'b0, 1'b0, 1'b0);
        check("arst_next_last", 256'(rdq_last), 256'(0));
        apply(1'b1, 8'h62, 1'b0, 1'b0, 1'b0);
        apply(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check("arst_burst_end", 256'(rdq_last), 256'(1));
        apply(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Push into an empty queue with the consumer ready.
        apply(1'b1, 8'h71, 1'b1, 1'b0, 1'b0);
`ifdef DRAM_RDQ_BYPASS_EN
        check("byp_cnt", 256'(rdq_cnt), 256'(0));
`else
        check("byp_cnt", 256'(rdq_cnt), 256'(1));
        check("lat_data", rdq_data, {32{8'h71}});
`endif
        apply(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check("final_cnt", 256'(rdq_cnt), 256'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
